// File: rtl/cv32e40px_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package cv32e40px_wb_pkg;

    localparam int unsigned NUM_SRC_DEFAULT = 3;
    localparam int unsigned WB_ADDR_WIDTH   = 6;
    localparam int unsigned WB_DATA_WIDTH   = 32;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_LSU = 1;
    localparam int unsigned SRC_FPU = 2;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/cv32e40px_wb_buffer.sv
// One-entry holding register between a result producer and the write-back arbiter.
module cv32e40px_wb_buffer
    import cv32e40px_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                  clk_int,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  issue_i,
    output logic                  full_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  full_d, full_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;

    // Ready depends only on local state and the arbiter's issue decision, never on valid_i.
    assign ready_o = ~full_q | issue_i;
    assign full_o  = full_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

    // Next state: load on handshake, otherwise empty when issued.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (valid_i && ready_o) begin
            full_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end else if (issue_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/cv32e40px_rf_wb_arbiter.sv
// Write-back arbiter driving the two register-file write ports plus busy scoreboard.
// Define CV32E40PX_WB_ROUND_ROBIN_EN for rotating port priority (default: fixed, index 0 highest).
module cv32e40px_rf_wb_arbiter
    import cv32e40px_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = NUM_SRC_DEFAULT,
    parameter int FPU        = 0
) (
    input  logic                             clk_int,
    input  logic                             rst_n,
    input  logic [NUM_SRC-1:0]               src_valid_i,
    output logic [NUM_SRC-1:0]               src_ready_o,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    src_addr_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_data_i,
    input  logic                             alloc_valid_i,
    input  logic [ADDR_WIDTH-1:0]            alloc_addr_i,
    output logic                             we_a_o,
    output logic [ADDR_WIDTH-1:0]            waddr_a_o,
    output logic [DATA_WIDTH-1:0]            wdata_a_o,
    output logic                             we_b_o,
    output logic [ADDR_WIDTH-1:0]            waddr_b_o,
    output logic [DATA_WIDTH-1:0]            wdata_b_o,
    output logic [(2**ADDR_WIDTH)-1:0]       busy_o
);

    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int NUM_REG = 2 ** ADDR_WIDTH;

    logic [NUM_SRC-1:0]    full_s, null_s, cand_s, issue_s;
    logic [ADDR_WIDTH-1:0] addr_s [NUM_SRC];
    logic [DATA_WIDTH-1:0] data_s [NUM_SRC];
    logic                  a_found_s, b_found_s;
    int                    a_idx_s, b_idx_s;
    int                    start_s;
    logic                  alloc_null_s;
    logic [NUM_REG-1:0]    busy_d, busy_q;

    // Address 0 and, without an FP bank, the FP half are sinks that never reach the file.
    function automatic logic is_null_addr(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == '0) || ((FPU == 0) && addr[ADDR_WIDTH-1]);
    endfunction

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_buf
        cv32e40px_wb_buffer #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_buf (
            .clk_int (clk_int),
            .rst_n   (rst_n),
            .valid_i (src_valid_i[s]),
            .ready_o (src_ready_o[s]),
            .addr_i  (src_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]),
            .data_i  (src_data_i[s*DATA_WIDTH +: DATA_WIDTH]),
            .issue_i (issue_s[s]),
            .full_o  (full_s[s]),
            .addr_o  (addr_s[s]),
            .data_o  (data_s[s])
        );
        assign null_s[s] = is_null_addr(addr_s[s]);
    end

    assign cand_s = full_s & ~null_s;

`ifdef CV32E40PX_WB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_d, rr_q;

    // Port-A priority rotates to the buffer after the last port-A winner.
    always_comb begin
        rr_d = rr_q;
        if (a_found_s) begin
            rr_d = (a_idx_s + 1 >= NUM_SRC) ? IDX_W'(0) : IDX_W'(a_idx_s + 1);
        end else begin
            rr_d = rr_q;
        end
    end

    // Rotating priority pointer.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign start_s = int'(rr_q);
`else
    assign start_s = 0;
`endif

    // Pick port A and B candidates; a same-address B candidate blocks, with no promotion past it.
    always_comb begin
        logic b_seen;
        int   idx;
        a_found_s = 1'b0;
        b_seen    = 1'b0;
        a_idx_s   = 0;
        b_idx_s   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = start_s + k;
            idx = (idx >= NUM_SRC) ? idx - NUM_SRC : idx;
            if (cand_s[idx] && !a_found_s) begin
                a_found_s = 1'b1;
                a_idx_s   = idx;
            end else if (cand_s[idx] && !b_seen) begin
                b_seen  = 1'b1;
                b_idx_s = idx;
            end else begin
                b_seen = b_seen;
            end
        end
        b_found_s = b_seen && (addr_s[b_idx_s] != addr_s[a_idx_s]);
    end

    // Null buffers drain unconditionally; real buffers drain only when granted a port.
    always_comb begin
        issue_s = full_s & null_s;
        if (a_found_s) begin
            issue_s[a_idx_s] = 1'b1;
        end else begin
            issue_s = issue_s;
        end
        if (b_found_s) begin
            issue_s[b_idx_s] = 1'b1;
        end else begin
            issue_s = issue_s;
        end
    end

    assign we_a_o    = a_found_s;
    assign waddr_a_o = a_found_s ? addr_s[a_idx_s] : '0;
    assign wdata_a_o = a_found_s ? data_s[a_idx_s] : '0;
    assign we_b_o    = b_found_s;
    assign waddr_b_o = b_found_s ? addr_s[b_idx_s] : '0;
    assign wdata_b_o = b_found_s ? data_s[b_idx_s] : '0;

    assign alloc_null_s = is_null_addr(alloc_addr_i);

    // Clear on issue (latches become transparent next cycle); a same-edge alloc overrides.
    always_comb begin
        busy_d = busy_q;
        if (we_a_o) begin
            busy_d[waddr_a_o] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (we_b_o) begin
            busy_d[waddr_b_o] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (alloc_valid_i && !alloc_null_s) begin
            busy_d[alloc_addr_i] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule
